// File: rtl/rebuilder_pkg.sv
// Shared types and defaults for the dividend rebuilder pipeline.
package rebuilder_pkg;

  localparam int QW_DEF = 3;
  localparam int DW_DEF = 2;

  // Product width: wide enough for (2^DW-1)*(2^QW-1) + (2^DW-1).
  function automatic int pw(input int qw, input int dw);
    return qw + dw;
  endfunction

  localparam int PW_DEF = pw(QW_DEF, DW_DEF);

  // One pipeline slot. Field widths follow the package defaults, so a
  // differently sized instance needs QW_DEF/DW_DEF changed here as well.
  typedef struct packed {
    logic              valid;
    logic [PW_DEF-1:0] acc;
    logic [QW_DEF-1:0] q;
    logic [DW_DEF-1:0] divisor;
    logic              rem_ok;
    logic              div_zero;
  } stage_t;

endpackage

// File: rtl/rebuilder_stage.sv
// One add-and-register stage: adds divisor<<I when quotient bit I is set.
// Stage 0 also derives rem_ok/div_zero; the last stage derives fits.
module rebuilder_stage
  import rebuilder_pkg::*;
#(
  parameter int I = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  stage_t stage_in,
  input  logic   fits_in,
  output stage_t stage_out,
  output logic   fits_out
);

  logic [PW_DEF-1:0] addend;
  logic [PW_DEF-1:0] acc_next;
  logic              rem_ok_next;
  logic              div_zero_next;
  logic              fits_next;

  // Partial product for this quotient bit and the flags travelling with it.
  always_comb begin
    addend = '0;
    if (stage_in.q[I]) addend = PW_DEF'(stage_in.divisor) << I;
    acc_next = stage_in.acc + addend;
    if (I == 0) begin
      // At stage 0 the accumulator still holds the bare remainder.
      rem_ok_next   = stage_in.acc[DW_DEF-1:0] < stage_in.divisor;
      div_zero_next = (stage_in.divisor == '0);
    end else begin
      rem_ok_next   = stage_in.rem_ok;
      div_zero_next = stage_in.div_zero;
    end
    fits_next = (I == QW_DEF - 1) ? ~|acc_next[PW_DEF-1:QW_DEF] : fits_in;
  end

  // Stage register: holds on stall, payload only loads with valid data so
  // the outputs keep their last values across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_out <= '0;
      fits_out  <= 1'b0;
    end else if (!hold) begin
      stage_out.valid <= stage_in.valid;
      if (stage_in.valid) begin
        stage_out.acc      <= acc_next;
        stage_out.q        <= stage_in.q;
        stage_out.divisor  <= stage_in.divisor;
        stage_out.rem_ok   <= rem_ok_next;
        stage_out.div_zero <= div_zero_next;
        fits_out           <= fits_next;
      end
    end
  end

endmodule

// File: rtl/dividend_rebuilder.sv
// Rebuilds dividend = q*divisor + remainder in a QW-stage pipeline,
// one quotient bit per stage, LSB first, with valid/ready handshakes.
module dividend_rebuilder
  import rebuilder_pkg::*;
#(
  parameter int QW = QW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] q,
  input  logic [DW-1:0] divisor,
  input  logic [DW-1:0] remainder,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW+DW-1:0] product,
  output logic          fits,
  output logic          rem_ok,
  output logic          div_zero
);

  localparam int PW = pw(QW, DW);

  stage_t        stage0_in;
  stage_t        pipe_out [QW];
  logic [QW:0]   fits_c;
  logic          stall;

  // The whole pipeline freezes only while a finished result is refused.
  assign stall    = pipe_out[QW-1].valid && !out_ready;
  assign in_ready = !stall;
  assign fits_c[0] = 1'b0;

  // Pack the incoming triple; the accumulator starts at the remainder.
  always_comb begin
    stage0_in         = '0;
    stage0_in.valid   = in_valid;
    stage0_in.acc     = PW'(remainder);
    stage0_in.q       = q;
    stage0_in.divisor = divisor;
  end

  for (genvar gi = 0; gi < QW; gi++) begin : g_stage
    stage_t s_in;
    if (gi == 0) begin : g_first
      assign s_in = stage0_in;
    end else begin : g_rest
      assign s_in = pipe_out[gi-1];
    end

    rebuilder_stage #(.I(gi)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .hold     (stall),
      .stage_in (s_in),
      .fits_in  (fits_c[gi]),
      .stage_out(pipe_out[gi]),
      .fits_out (fits_c[gi+1])
    );
  end

  assign out_valid = pipe_out[QW-1].valid;
  assign product   = pipe_out[QW-1].acc;
  assign rem_ok    = pipe_out[QW-1].rem_ok;
  assign div_zero  = pipe_out[QW-1].div_zero;
  assign fits      = fits_c[QW];

endmodule

// File: tb/tb_dividend_rebuilder.sv
// Scoreboard bench for dividend_rebuilder at default parameters.
module tb_dividend_rebuilder;

  localparam int QW = 3;
  localparam int DW = 2;
  localparam int PW = QW + DW;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] q;
  logic [DW-1:0] divisor;
  logic [DW-1:0] remainder;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          fits;
  logic          rem_ok;
  logic          div_zero;

  typedef struct packed {
    logic [PW-1:0] product;
    logic          fits;
    logic          rem_ok;
    logic          div_zero;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 0;

  dividend_rebuilder #(.QW(QW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .q        (q),
    .divisor  (divisor),
    .remainder(remainder),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .fits     (fits),
    .rem_ok   (rem_ok),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pushes the model result at every acceptance, pops and compares at every
  // output handshake. Sampled on the falling edge.
  task automatic scoreboard_monitor();
    exp_t e;
    exp_t got;
    int   p;
    forever begin
      @(negedge clk);
      if (!rst && in_valid && in_ready) begin
        p = int'(q) * int'(divisor) + int'(remainder);
        e.product  = PW'(p);
        e.fits     = (p < (1 << QW));
        e.rem_ok   = (remainder < divisor);
        e.div_zero = (divisor == '0);
        sb_q.push_back(e);
      end
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got product=%0d, expected no result", product);
        end else begin
          e   = sb_q.pop_front();
          got = {product, fits, rem_ok, div_zero};
          if (got !== e) begin
            errors++;
            $display("FAIL sb_result: got p=%0d f=%0b r=%0b z=%0b, expected p=%0d f=%0b r=%0b z=%0b",
                     product, fits, rem_ok, div_zero, e.product, e.fits, e.rem_ok, e.div_zero);
          end
        end
      end
    end
  endtask

  // Present a triple and wait (bounded) until it is taken.
  task automatic send(input int qv, input int dv, input int rv);
    bit taken = 0;
    in_valid  = 1'b1;
    q         = QW'(qv);
    divisor   = DW'(dv);
    remainder = DW'(rv);
    for (int n = 0; n < 200 && !taken; n++) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!taken) begin
      errors++;
      $display("FAIL send_timeout: got accepted=0, expected accepted=1 for (%0d,%0d,%0d)", qv, dv, rv);
    end
  endtask

  // Stop presenting and wait (bounded) until every expected result came out.
  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 500 && sb_q.size() != 0; n++) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    q         = 3'd7;
    divisor   = 2'd3;
    remainder = 2'd3;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, product, fits, rem_ok, div_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b p=%0d f=%0b r=%0b z=%0b, expected all 0",
               out_valid, product, fits, rem_ok, div_zero);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b, expected 1", in_ready);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_accept: got out_valid=%0b, expected 0", out_valid);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Directed triples with exact latency: valid only after the third edge.
  task automatic test_directed();
    int   tq [3] = '{3, 7, 5};
    int   td [3] = '{2, 3, 0};
    int   tr [3] = '{0, 3, 1};
    exp_t te [3] = '{{5'd6, 1'b1, 1'b1, 1'b0},
                     {5'd24, 1'b0, 1'b0, 1'b0},
                     {5'd1, 1'b1, 1'b0, 1'b1}};
    drain();
    for (int k = 0; k < 3; k++) begin
      in_valid  = 1'b1;
      q         = QW'(tq[k]);
      divisor   = DW'(td[k]);
      remainder = DW'(tr[k]);
      for (int e = 1; e <= 3; e++) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== (e == 3)) begin
          errors++;
          $display("FAIL latency_%0d_edge%0d: got out_valid=%0b, expected %0b", k, e, out_valid, (e == 3));
        end
      end
      checks++;
      if ({product, fits, rem_ok, div_zero} !== te[k]) begin
        errors++;
        $display("FAIL directed_%0d: got p=%0d f=%0b r=%0b z=%0b, expected p=%0d f=%0b r=%0b z=%0b",
                 k, product, fits, rem_ok, div_zero,
                 te[k].product, te[k].fits, te[k].rem_ok, te[k].div_zero);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    drain();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    q = 3'd2; divisor = 2'd3; remainder = 2'd1;
    @(posedge clk); #1;
    q = 3'd1; divisor = 2'd1; remainder = 2'd0;
    @(posedge clk); #1;
    q = 3'd4; divisor = 2'd2; remainder = 2'd1;
    @(posedge clk); #1;
    q = 3'd6; divisor = 2'd1; remainder = 2'd0;
    out_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, product} !== {1'b0, 1'b1, 5'd7}) begin
        errors++;
        $display("FAIL stall_%0d: got in_ready=%0b out_valid=%0b p=%0d, expected 0 1 7",
                 s, in_ready, out_valid, product);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got in_ready=%0b, expected 1", in_ready);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    drain();
    send(2, 1, 0);
    send(3, 1, 1);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    checks++;
    if ({out_valid, product} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got out_valid=%0b p=%0d, expected 0 0", out_valid, product);
    end
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_stale: got out_valid=%0b, expected 0", out_valid);
      end
    end
    @(posedge clk); #1;
    send(1, 1, 1);
    in_valid = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid;
    end
    checks++;
    if (!seen || product !== 5'd2) begin
      errors++;
      $display("FAIL post_reset: got out_valid=%0b p=%0d, expected 1 2", seen, product);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_sweep();
    drain();
    rand_ready = 1;
    for (int qi = 0; qi < (1 << QW); qi++)
      for (int di = 0; di < (1 << DW); di++)
        for (int ri = 0; ri < (1 << DW); ri++)
          send(qi, di, ri);
    drain();
    rand_ready = 0;
    out_ready  = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    q         = '0;
    divisor   = '0;
    remainder = '0;
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dividend_rebuilder.md
DIVIDEND_REBUILDER -- requirements
Module: dividend_rebuilder

Interface
REQ-001 The block SHALL use parameter QW, default 3, meaning quotient width in bits.
REQ-002 The block SHALL use parameter DW, default 2, meaning divisor and remainder width in bits.
REQ-003 The block SHALL derive constant PW = QW+DW, the product width; it is not overridable.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: an input triple is presented.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the triple this cycle.
REQ-008 The block SHALL have port q, input, QW bits: unsigned quotient.
REQ-009 The block SHALL have port divisor, input, DW bits: unsigned divisor.
REQ-010 The block SHALL have port remainder, input, DW bits: unsigned remainder.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 The block SHALL have port product, output, PW bits: q*divisor+remainder.
REQ-014 The block SHALL have port fits, output, 1 bit: product < 2^QW, so it is representable as a QW-bit dividend.
REQ-015 The block SHALL have port rem_ok, output, 1 bit: remainder < divisor.
REQ-016 The block SHALL have port div_zero, output, 1 bit: divisor == 0.

Function
REQ-017 The block SHALL accept a triple on a rising edge where in_valid && in_ready; this is the accepting edge (edge 1).
REQ-018 The block SHALL implement a QW-stage pipeline, one registered stage per quotient bit, processed LSB first.
- Stage 0 accumulator: acc = remainder + (q[0] ? divisor : 0).
- Stage i: acc += (q[i] ? divisor<<i : 0).
REQ-019 All accumulator arithmetic SHALL be unsigned and PW bits wide; overflow is impossible because the maximum value is (2^DW-1)*2^QW < 2^PW.
REQ-020 The result, fits, rem_ok and div_zero SHALL be registered and SHALL appear with out_valid=1 after edge QW (latency QW cycles; 3 at defaults).
REQ-021 The block SHALL compute rem_ok and div_zero from the stage-0 inputs and carry them down the pipeline with the data; fits SHALL be computed from the final accumulator.
REQ-022 Throughput SHALL be one triple per cycle when out_ready=1; results SHALL leave in acceptance order, with none dropped or duplicated.
REQ-023 Backpressure SHALL follow the rule stall = out_valid && !out_ready:
- When stall=1, every stage register and its valid bit hold.
- in_ready SHALL equal !stall (combinational).
REQ-024 A valid bit SHALL be cleared for a stage whose upstream supplies no data, creating a bubble; bubbles SHALL NOT block acceptance.
REQ-025 While out_valid=0, product, fits, rem_ok and div_zero SHALL hold their last values and carry no meaning.
REQ-026 If in_valid=1 while in_ready=0, the triple SHALL NOT be taken; the producer holds it.
REQ-027 divisor == 0 SHALL be legal and give product=remainder, div_zero=1 and rem_ok=0.

Reset
REQ-028 Asserting rst SHALL immediately clear all stage valid bits, accumulators and flags, so that out_valid=0 and product=0, fits=0, rem_ok=0 and div_zero=0.
REQ-029 During reset, in_ready SHALL be 1, but no triple SHALL be accepted while rst=1.
REQ-030 Reset mid-operation SHALL discard all in-flight triples; none SHALL appear after rst deasserts.
REQ-031 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-032 Package rebuilder_pkg SHALL hold the default QW/DW, function pw(), and a packed struct stage_t with fields valid, acc[PW], q[QW], divisor[DW], rem_ok and div_zero.
REQ-033 One sub-module, rebuilder_stage, SHALL implement one add-and-register stage: parameter index i, input stage_t, a hold input, and output stage_t.
REQ-034 The top level SHALL generate QW instances of rebuilder_stage; the top level SHALL contain only the stall logic and output mapping.

Verification
REQ-035 Bench scenario: q=3, divisor=2, remainder=0 -> after 3 cycles product=6, fits=1, rem_ok=1, div_zero=0.
REQ-036 Bench scenario: q=7, divisor=3, remainder=3 -> product=24, fits=0, rem_ok=0, div_zero=0.
REQ-037 Bench scenario: q=5, divisor=0, remainder=1 -> product=1, div_zero=1, rem_ok=0, fits=1.
REQ-038 Bench scenario: stream (2,3,1), (1,1,0), (4,2,1) and (6,1,0) back-to-back with out_ready low for 2 cycles mid-stream -> products 7, 1, 9 and 6 in order, each held while stalled, in_ready=0 during the stall.
REQ-039 Bench scenario: accept 2 triples, assert rst for 1 cycle -> out_valid=0 at once and no stale result afterwards; a new triple (1,1,1) gives product=2.
REQ-040 Bench scenario: exhaustive sweep of all 2^(QW+2DW) triples with random out_ready -> every result matches the model q*divisor+remainder and the flag equations.
